soc_system_app_pio_in_cond: RTL and testbench

//  Input conditioner directly upstream of the app PIO's 32-bit in_port. Synchronises raw

---
 rtl/soc_system_app_pio_pkg.sv | 19 +
 rtl/app_pio_debounce_bit.sv | 58 +++++
 rtl/soc_system_app_pio_in_cond.sv | 60 ++++++
 tb/tb_soc_system_app_pio_in_cond.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/soc_system_app_pio_pkg.sv
// Shared constants and sizing helper for the app PIO input conditioner.
// Combinational only; no latency, no backpressure.
package soc_system_app_pio_pkg;

  localparam int APP_PIO_WIDTH          = 32;
  localparam int APP_PIO_TICK_DIV       = 50000;
  localparam int APP_PIO_STABLE_SAMPLES = 4;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((longint'(1) << i) < longint'(value)) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/app_pio_debounce_bit.sv
// One conditioned bit: sync chain, tick-qualified debounce counter, registered edge pulses.
// Latency SYNC_STAGES + up to STABLE_SAMPLES ticks; no backpressure (free-running input).
module app_pio_debounce_bit
  import soc_system_app_pio_pkg::*;
#(
  parameter int   SYNC_STAGES    = 2,
  parameter int   STABLE_SAMPLES = APP_PIO_STABLE_SAMPLES,
  parameter logic RESET_VALUE    = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic tick,
  input  logic raw,
  output logic state,
  output logic rise,
  output logic fall
);

  localparam int CW = clog2_min1(STABLE_SAMPLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CW-1:0]          cnt;
  logic                   sync_q;

  assign sync_q = sync_r[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{RESET_VALUE}};
      cnt    <= '0;
      state  <= RESET_VALUE;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (!enable) begin
        cnt <= '0;
      end else if (tick) begin
        if (sync_q == state) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          // Pulses land on the same edge as the flip so they align with the new value.
          state <= sync_q;
          cnt   <= '0;
          rise  <= sync_q;
          fall  <= ~sync_q;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/soc_system_app_pio_in_cond.sv
// Synchronises and debounces WIDTH raw inputs for the PIO in_port, with edge pulses and change strobe.
// Latency SYNC_STAGES + up to TICK_DIV*STABLE_SAMPLES cycles; no backpressure.
module soc_system_app_pio_in_cond
  import soc_system_app_pio_pkg::*;
#(
  parameter int               WIDTH          = APP_PIO_WIDTH,
  parameter int               SYNC_STAGES    = 2,
  parameter int               TICK_DIV       = APP_PIO_TICK_DIV,
  parameter int               STABLE_SAMPLES = APP_PIO_STABLE_SAMPLES,
  parameter logic [WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] debounced_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             change_strobe
);

  localparam int PW = clog2_min1(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = enable && (presc == PRESC_LAST);

  // Held at zero while disabled so the first tick after enabling is a full period away.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    app_pio_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .RESET_VALUE    (RESET_VALUE[g])
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .tick   (tick),
      .raw    (raw_in[g]),
      .state  (debounced_out[g]),
      .rise   (rise_pulse[g]),
      .fall   (fall_pulse[g])
    );
  end

  assign change_strobe = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_soc_system_app_pio_in_cond.sv
// Directed vector bench for the PIO input conditioner (TICK_DIV=4, STABLE_SAMPLES=3).
module tb_soc_system_app_pio_in_cond;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] raw_in;
  logic [31:0] debounced_out;
  logic [31:0] rise_pulse;
  logic [31:0] fall_pulse;
  logic        change_strobe;

  int checks;
  int failures;

  soc_system_app_pio_in_cond #(
    .WIDTH          (32),
    .SYNC_STAGES    (2),
    .TICK_DIV       (4),
    .STABLE_SAMPLES (3),
    .RESET_VALUE    (32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .raw_in        (raw_in),
    .debounced_out (debounced_out),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .change_strobe (change_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] raw;
    int          cyc;
    logic [31:0] deb;
    logic [31:0] rise_acc;
    logic [31:0] fall_acc;
    int          strobes;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] rise_acc, fall_acc;
  int          strobe_cnt;
  int          cyc;
  int          last_flip;
  int          min_gap;

  function automatic vec_t mk(input logic rst, input logic en, input logic [31:0] raw,
                              input int n, input logic [31:0] deb, input logic [31:0] r,
                              input logic [31:0] f, input int s);
    vec_t v;
    v.rst = rst; v.en = en; v.raw = raw; v.cyc = n;
    v.deb = deb; v.rise_acc = r; v.fall_acc = f; v.strobes = s;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock edge; outputs sampled 1ns later and folded into the segment accumulators.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    rise_acc   = rise_acc | rise_pulse;
    fall_acc   = fall_acc | fall_pulse;
    strobe_cnt = strobe_cnt + int'(change_strobe);
    check32("strobe_vs_pulses", {31'b0, change_strobe}, {31'b0, |(rise_pulse | fall_pulse)});
    if (rise_pulse[0] || fall_pulse[0]) begin
      if (last_flip >= 0 && (cyc - last_flip) < min_gap) min_gap = cyc - last_flip;
      last_flip = cyc;
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    last_flip = -1; min_gap = 1000;
    reset = 1'b1; enable = 1'b1; raw_in = 32'h0;

    // Edge numbering in comments counts from the first edge after reset release.
    tbl.push_back(mk(1, 1, 32'h0,        2,   32'h0,        32'h0,        32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h1,        11,  32'h0,        32'h0,        32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h1,        1,   32'h1,        32'h1,        32'h0, 1)); // edge 12
    tbl.push_back(mk(0, 1, 32'h1,        4,   32'h1,        32'h0,        32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h0,        11,  32'h1,        32'h0,        32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h0,        1,   32'h0,        32'h0,        32'h1, 1)); // edge 28
    tbl.push_back(mk(0, 1, 32'h8000_0003, 11, 32'h0,        32'h0,        32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h8000_0003, 1,  32'h8000_0003, 32'h8000_0003, 32'h0, 1)); // edge 40
    tbl.push_back(mk(0, 1, 32'h8000_0003, 3,  32'h8000_0003, 32'h0,        32'h0, 0));
    // bit4 mismatches at ticks 48,52, matches at 56, mismatches from 60: flips at 68
    tbl.push_back(mk(0, 1, 32'h8000_0013, 9,  32'h8000_0003, 32'h0,        32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h8000_0003, 4,  32'h8000_0003, 32'h0,        32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h8000_0013, 11, 32'h8000_0003, 32'h0,        32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h8000_0013, 1,  32'h8000_0013, 32'h10,       32'h0, 1)); // edge 68
    tbl.push_back(mk(0, 0, 32'hFFFF_FFFF, 100, 32'h8000_0013, 32'h0,       32'h0, 0));
    tbl.push_back(mk(0, 1, 32'hFFFF_FFFF, 11, 32'h8000_0013, 32'h0,        32'h0, 0));
    tbl.push_back(mk(0, 1, 32'hFFFF_FFFF, 1,  32'hFFFF_FFFF, 32'h7FFF_FFEC, 32'h0, 1)); // edge 180
    tbl.push_back(mk(0, 1, 32'h0,        8,   32'hFFFF_FFFF, 32'h0,        32'h0, 0));
    tbl.push_back(mk(1, 1, 32'h0,        1,   32'h0,        32'h0,        32'h0, 0)); // mid-debounce reset
    tbl.push_back(mk(0, 1, 32'h5,        11,  32'h0,        32'h0,        32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h5,        1,   32'h5,        32'h5,        32'h0, 1));
    tbl.push_back(mk(0, 1, 32'h5,        2,   32'h5,        32'h0,        32'h0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; enable = tbl[i].en; raw_in = tbl[i].raw;
      rise_acc = '0; fall_acc = '0; strobe_cnt = 0;
      repeat (tbl[i].cyc) step();
      check32($sformatf("row%0d_debounced", i), debounced_out, tbl[i].deb);
      check32($sformatf("row%0d_rise", i), rise_acc, tbl[i].rise_acc);
      check32($sformatf("row%0d_fall", i), fall_acc, tbl[i].fall_acc);
      check32($sformatf("row%0d_strobes", i), 32'(strobe_cnt), 32'(tbl[i].strobes));
    end

    // Bit0 toggling every cycle: flips, if any, must be at least 12 cycles apart.
    reset = 1'b1; enable = 1'b1; raw_in = 32'h0;
    repeat (2) step();
    reset = 1'b0;
    last_flip = -1; min_gap = 1000;
    rise_acc = '0; fall_acc = '0;
    for (int i = 0; i < 24; i++) begin
      raw_in[0] = ~raw_in[0];
      step();
    end
    raw_in = 32'h0;
    repeat (14) step();
    checks++;
    if (min_gap < 12) begin
      failures++;
      $display("FAIL toggle_flip_gap: got %0d cycles expected >= 12", min_gap);
    end
    check32("toggle_settled", debounced_out, 32'h0);
    check32("toggle_other_bits", (rise_acc | fall_acc) & 32'hFFFF_FFFE, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
